// File: rtl/out_cu_pkg.sv
// Shared definitions for the FIFO_OUT round-robin control unit:
// FSM state encoding, default word geometry and an index-width helper.
package out_cu_pkg;

  // Default result word: 8-bit ID followed by 17 data bits.
  localparam int FIFO_OUT_WIDTH_DEF = 25;
  localparam int ID_SIZE            = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Bits needed to hold a channel index (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first requesting
// channel at or above ptr, wrapping from NUM_CH-1 back to channel 0.
module rr_arbiter
  import out_cu_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_req
);

  // Requests at or above the pointer take priority over wrapped ones.
  logic [NUM_CH-1:0] upper_req;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_upper
      assign upper_req[gi] = req[gi] && (IDX_W'(gi) >= ptr);
    end
  endgenerate

  assign any_req = |req;

  // Lowest wrapped request first, then overridden by the lowest upper request.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/out_rr_control_unit.sv
// Round-robin collector of ALU results into FIFO_OUT.
// IDLE grants a channel and latches its word, WRITE strobes it into the
// FIFO once there is room, RELEASE waits for the granted valid to fall so
// one result is never written twice.
// Optional feature: define OUT_RR_WRCNT_EN to add the saturating wr_count.
module out_rr_control_unit
  import out_cu_pkg::*;
#(
  parameter int FIFO_OUT_WIDTH = FIFO_OUT_WIDTH_DEF,
  parameter int NUM_CH         = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                valid_res,
  input  logic [NUM_CH*FIFO_OUT_WIDTH-1:0] result_bus,
  input  logic                             ready_f_res,
  output logic [FIFO_OUT_WIDTH-1:0]        fifo_res,
  output logic                             w_en_out,
  output logic [NUM_CH-1:0]                written
`ifdef OUT_RR_WRCNT_EN
  ,
  output logic [CNT_WIDTH-1:0]             wr_count
`endif
);

  localparam int IDX_W = idx_width(NUM_CH);

  state_t              state_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [NUM_CH-1:0]   sel_reg;

  logic [NUM_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [IDX_W-1:0]    ptr_next;

  logic [FIFO_OUT_WIDTH-1:0] ch_word [NUM_CH];

  // Split the concatenated result bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_split
      assign ch_word[gi] = result_bus[gi*FIFO_OUT_WIDTH +: FIFO_OUT_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (valid_res),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Pointer moves to the channel just after the winner, wrapping to 0.
  assign ptr_next = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;

  // Control FSM; strobe and acknowledge are registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      idx_reg    <= '0;
      sel_reg    <= '0;
      fifo_res   <= '0;
      w_en_out   <= 1'b0;
      written    <= '0;
    end else begin
      w_en_out <= 1'b0;
      written  <= '0;
      case (state_reg)
        IDLE: begin
          if (ready_f_res && arb_any) begin
            fifo_res   <= ch_word[arb_idx];
            idx_reg    <= arb_idx;
            sel_reg    <= arb_grant;
            rr_ptr_reg <= ptr_next;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          // The word is already latched, so a falling valid here is ignored.
          if (ready_f_res) begin
            w_en_out  <= 1'b1;
            written   <= sel_reg;
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (!valid_res[idx_reg]) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef OUT_RR_WRCNT_EN
  // Saturating count of completed FIFO_OUT writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (w_en_out && (wr_count != {CNT_WIDTH{1'b1}})) begin
      wr_count <= wr_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/out_rr_control_unit.md
OUT_RR_CONTROL_UNIT -- requirements
Module: out_rr_control_unit

Interface
REQ-001 Parameter FIFO_OUT_WIDTH, default 25, is the width of one result word (8-bit ID plus data).
REQ-002 Parameter NUM_CH, default 2, is the number of ALU result channels, legal range 2..8.
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the optional write counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 valid_res  in  NUM_CH  per-channel result valid, held by the ALU until it sees its written pulse.
REQ-008 result_bus  in  NUM_CH*FIFO_OUT_WIDTH  concatenated results; channel k occupies bits [k*FIFO_OUT_WIDTH +: FIFO_OUT_WIDTH].
REQ-009 ready_f_res  in  1  FIFO_OUT not full.
REQ-010 fifo_res  out  FIFO_OUT_WIDTH  registered word to FIFO_OUT.
REQ-011 w_en_out  out  1  one-cycle FIFO_OUT write strobe.
REQ-012 written  out  NUM_CH  one-hot, one-cycle acknowledge to the granted channel.
REQ-013 wr_count  out  CNT_WIDTH  total writes; present only under OUT_RR_WRCNT_EN.

Function
REQ-014 The FSM SHALL have three states: IDLE, WRITE and RELEASE.
REQ-015 IDLE: when ready_f_res=1 and |valid_res=1, the block SHALL latch the winner index and its result into fifo_res and go to WRITE; otherwise it SHALL stay in IDLE.
REQ-016 The winner SHALL be the first channel with valid set, searching upward from rr_ptr and wrapping from NUM_CH-1 to 0.
REQ-017 After each grant, rr_ptr SHALL become (winner+1) mod NUM_CH; it SHALL not change otherwise.
REQ-018 WRITE with ready_f_res=1: w_en_out=1 and written[idx]=1 for exactly that cycle, then go to RELEASE.
REQ-019 WRITE with ready_f_res=0: the block SHALL hold fifo_res, keep w_en_out and written at 0, and stay in WRITE.
REQ-020 RELEASE: the block SHALL stay until valid_res[idx]=0, then go to IDLE; this prevents a double write of one result.
REQ-021 Latency SHALL be one cycle from IDLE grant to w_en_out; minimum spacing between writes SHALL be 3 cycles.
REQ-022 w_en_out and written SHALL be driven from registers, with no combinational path from inputs.
REQ-023 fifo_res SHALL change only on a grant; it SHALL be stable while w_en_out=1.
REQ-024 A deassertion of the granted valid during WRITE SHALL NOT cancel the write, because the word is already latched.
REQ-025 Channels that are not granted SHALL keep their pending valid untouched and SHALL never see written.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, rr_ptr=0, fifo_res=0, w_en_out=0, written=0, wr_count=0.
REQ-027 A reset in WRITE or RELEASE SHALL abort with no strobe; the channel's valid, still high, is re-arbitrated after reset.

Configuration
REQ-028 With OUT_RR_WRCNT_EN defined, wr_count SHALL increment on every w_en_out and saturate at all-ones.
REQ-029 Without OUT_RR_WRCNT_EN, the wr_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package out_cu_pkg SHALL hold the state encoding (IDLE=2'd0, WRITE=2'd1, RELEASE=2'd2) and the default FIFO_OUT_WIDTH and ID_SIZE constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter: combinational request and pointer in, one-hot grant and index out.
REQ-032 The FSM, data register and counter SHALL stay in out_rr_control_unit.

Verification (NUM_CH=2, FIFO_OUT_WIDTH=25)
REQ-033 Single channel: valid_res=01, result ch0=25'h0A_1234, ready=1 -> next cycle fifo_res=25'h0A_1234, w_en_out=1, written=01 for one cycle.
REQ-034 Both valid continuously, ALU drops valid 1 cycle after written and reasserts 2 cycles later -> grants alternate ch0, ch1, ch0, ch1; no channel is granted twice in a row.
REQ-035 ready_f_res=0 for 5 cycles while in WRITE -> no strobe, fifo_res stable; strobe occurs in the cycle ready returns to 1.
REQ-036 ch0 holds valid for 6 cycles after written -> exactly one w_en_out; the block stays in RELEASE until valid falls.
REQ-037 rst pulsed in WRITE -> all outputs 0 immediately; the pending ch1 result is written once after reset.
REQ-038 OUT_RR_WRCNT_EN with CNT_WIDTH=4 -> after 20 writes, wr_count=4'hF.
